// File: rtl/bird_motion.sv
// Vertical motion of the bird: hover in IDLE, gravity/flap physics in FLY,
// gravity-only fall in DYING, frozen in DEAD. All outputs come from flops.
module bird_motion #(
   parameter logic [8:0] START_HEIGHT  = 9'd200,
   parameter logic [8:0] GROUND_HEIGHT = 9'd440,
   parameter int         FLAP_VEL      = 6,
   parameter int         MAX_FALL_VEL  = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_tick,
   input  logic       flap_btn,
   input  logic       game_start,
   input  logic       collision,
   output logic [8:0] bird_height,
   output logic       bird_valid,
   output logic [2:0] bird_angle,
   output logic       bird_dead
);

   typedef enum logic [1:0] {StIdle, StFly, StDying, StDead} state_e;

   localparam logic signed [5:0] FlapVel = 6'(-FLAP_VEL);
   localparam logic signed [5:0] MaxVel  = 6'(MAX_FALL_VEL);

   state_e            state_q, state_d;
   logic signed [5:0] vel_q, vel_d, vel_grav;
   logic [8:0]        height_q, height_d;
   logic              flap_prev_q, flap_pend_q, flap_pend_d, flap_edge;
   logic              valid_q, dead_q, dead_d;
   logic [2:0]        angle_q, angle_d;
   logic signed [9:0] height_sum;
   logic              hit_ceiling, hit_ground;

   // Height step at 10 bits signed so both ceiling underflow and ground overshoot are visible.
   always_comb begin
      height_sum  = $signed({1'b0, height_q}) + $signed({{4{vel_q[5]}}, vel_q});
      hit_ceiling = height_sum[9];
      hit_ground  = !hit_ceiling && (height_sum >= $signed({1'b0, GROUND_HEIGHT}));
      vel_grav    = (vel_q >= MaxVel) ? MaxVel : vel_q + 6'sd1;
      flap_edge   = flap_btn & ~flap_prev_q;
   end

   // Next-state, physics update and registered-output decode.
   always_comb begin
      state_d     = state_q;
      height_d    = height_q;
      vel_d       = vel_q;
      flap_pend_d = flap_pend_q | flap_edge;

      unique case (state_q)
         StIdle: begin
            if (game_start) begin
               state_d     = StFly;
               height_d    = START_HEIGHT;
               vel_d       = FlapVel;
               flap_pend_d = 1'b0;
            end
         end
         StFly: begin
            if (frame_tick) begin
               // The tick consumes the pending flap; an edge on this same clock survives.
               flap_pend_d = flap_edge;
               if (hit_ceiling) begin
                  height_d = '0;
                  vel_d    = '0;
               end else if (hit_ground) begin
                  height_d = GROUND_HEIGHT;
                  state_d  = StDead;
               end else begin
                  height_d = height_sum[8:0];
                  vel_d    = flap_pend_q ? FlapVel : vel_grav;
               end
            end
            // Ground hit wins over a simultaneous collision.
            if (collision && (state_d != StDead)) begin
               state_d = StDying;
               if (vel_d < 0) begin
                  vel_d = '0;
               end
            end
         end
         StDying: begin
            if (frame_tick) begin
               if (hit_ground) begin
                  height_d = GROUND_HEIGHT;
                  state_d  = StDead;
               end else begin
                  height_d = height_sum[8:0];
                  vel_d    = vel_grav;
               end
            end
         end
         StDead: begin
            if (game_start) begin
               state_d  = StIdle;
               height_d = START_HEIGHT;
               vel_d    = '0;
            end
         end
      endcase

      dead_d = (state_d == StDead);
      if (dead_d) begin
         angle_d = 3'd4;
      end else if (vel_d < 0) begin
         angle_d = 3'd0;
      end else if (vel_d >= 6'sd6) begin
         angle_d = 3'd4;
      end else begin
         // vel 0..5 maps pairwise onto tilt 1..3
         angle_d = {1'b0, vel_d[2:1]} + 3'd1;
      end
   end

   // State, physics and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         height_q    <= START_HEIGHT;
         vel_q       <= '0;
         flap_prev_q <= 1'b0;
         flap_pend_q <= 1'b0;
         valid_q     <= 1'b0;
         angle_q     <= 3'd1;
         dead_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         height_q    <= height_d;
         vel_q       <= vel_d;
         flap_prev_q <= flap_btn;
         flap_pend_q <= flap_pend_d;
         valid_q     <= valid_q | frame_tick;
         angle_q     <= angle_d;
         dead_q      <= dead_d;
      end
   end

   assign bird_height = height_q;
   assign bird_valid  = valid_q;
   assign bird_angle  = angle_q;
   assign bird_dead   = dead_q;

endmodule

// File: tb/tb_bird_motion.sv
// Scoreboard bench for bird_motion: a behavioural model predicts the outputs
// for every clock; a monitor compares them one clock after each input set.
module tb_bird_motion;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame_tick = 1'b0;
   logic       flap_btn = 1'b0;
   logic       game_start = 1'b0;
   logic       collision = 1'b0;
   logic [8:0] bird_height;
   logic       bird_valid;
   logic [2:0] bird_angle;
   logic       bird_dead;

   bird_motion dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .frame_tick (frame_tick),
      .flap_btn   (flap_btn),
      .game_start (game_start),
      .collision  (collision),
      .bird_height(bird_height),
      .bird_valid (bird_valid),
      .bird_angle (bird_angle),
      .bird_dead  (bird_dead)
   );

   always #5 clk = ~clk;

   typedef struct {
      int h;
      int valid;
      int angle;
      int dead;
   } exp_t;

   exp_t sb[$];
   int errors = 0;
   int checks = 0;

   // Behavioural model: the bird as plain integers.
   localparam int M_IDLE = 0, M_FLY = 1, M_DYING = 2, M_DEAD = 3;
   int m_state = M_IDLE;
   int m_h = 200;
   int m_v = 0;
   bit m_pend = 0;
   bit m_prev = 0;
   bit m_valid = 0;

   function automatic int tilt(input int st, input int v);
      if (st == M_DEAD) return 4;
      if (v < 0) return 0;
      if (v >= 6) return 4;
      return v / 2 + 1;
   endfunction

   task automatic model_step();
      bit edge_f;
      bit consume;
      bit clr;
      int nh;
      int nv;
      consume = 0;
      clr = 0;
      if (!rst_n) begin
         m_state = M_IDLE; m_h = 200; m_v = 0; m_pend = 0; m_prev = 0; m_valid = 0;
         return;
      end
      edge_f = flap_btn && !m_prev;
      m_prev = flap_btn;
      if (frame_tick) m_valid = 1;
      case (m_state)
         M_IDLE: if (game_start) begin m_state = M_FLY; m_v = -6; clr = 1; end
         M_FLY: begin
            nv = m_v;
            if (frame_tick) begin
               consume = 1;
               nh = m_h + m_v;
               if (nh < 0) begin
                  m_h = 0; nv = 0;
               end else if (nh >= 440) begin
                  m_h = 440; m_state = M_DEAD;
               end else begin
                  m_h = nh;
                  nv = m_pend ? -6 : ((m_v + 1 > 8) ? 8 : m_v + 1);
               end
            end
            if (collision && m_state != M_DEAD) begin
               m_state = M_DYING;
               if (nv < 0) nv = 0;
            end
            m_v = nv;
         end
         M_DYING: if (frame_tick) begin
            nh = m_h + m_v;
            if (nh >= 440) begin
               m_h = 440; m_state = M_DEAD;
            end else begin
               m_h = nh;
               m_v = (m_v + 1 > 8) ? 8 : m_v + 1;
            end
         end
         default: if (game_start) begin m_state = M_IDLE; m_h = 200; m_v = 0; end
      endcase
      if (clr) m_pend = 0;
      else if (consume) m_pend = edge_f;
      else m_pend = m_pend | edge_f;
   endtask

   // Apply one clock worth of inputs and queue the response due after the next edge.
   task automatic cycle(input bit r, input bit t, input bit f, input bit s, input bit c);
      exp_t e;
      @(negedge clk);
      rst_n = r; frame_tick = t; flap_btn = f; game_start = s; collision = c;
      model_step();
      e.h = m_h;
      e.valid = m_valid;
      e.angle = tilt(m_state, m_v);
      e.dead = (m_state == M_DEAD);
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0);
   endtask

   task automatic tick();
      cycle(1, 1, 0, 0, 0);
      idle(1);
   endtask

   task automatic flap_tick();
      cycle(1, 0, 1, 0, 0);
      cycle(1, 1, 1, 0, 0);
      idle(1);
   endtask

   function automatic void check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
      end
   endfunction

   // Monitor: the DUT presents a registered result every clock.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("bird_height", int'(bird_height), e.h);
            check("bird_valid", int'(bird_valid), e.valid);
            check("bird_angle", int'(bird_angle), e.angle);
            check("bird_dead", int'(bird_dead), e.dead);
         end
      end
   end

   initial begin
      bit f_lvl;
      f_lvl = 0;
      // Reset, then the hover-to-flight climb and apex.
      cycle(0, 0, 0, 0, 0);
      cycle(0, 1, 1, 1, 1);
      idle(2);
      tick();
      cycle(1, 0, 0, 1, 0);
      idle(1);
      for (int i = 0; i < 7; i++) tick();
      // Long free fall to the ground, then frozen while dead.
      for (int i = 0; i < 60; i++) tick();
      // Restart coinciding with a frame tick, then fly into the ceiling.
      cycle(1, 1, 0, 1, 0);
      idle(1);
      cycle(1, 0, 0, 1, 0);
      for (int i = 0; i < 40; i++) flap_tick();
      for (int i = 0; i < 6; i++) tick();
      flap_tick();
      tick();
      // Collision: flaps ignored while dying, fall to ground, restart.
      cycle(1, 0, 0, 0, 1);
      idle(1);
      for (int i = 0; i < 5; i++) flap_tick();
      for (int i = 0; i < 60; i++) tick();
      cycle(1, 0, 0, 1, 0);
      idle(2);
      // Reset mid-flight once the bird has dropped past 300.
      cycle(1, 0, 0, 1, 0);
      for (int i = 0; i < 80 && m_h < 300 && m_state == M_FLY; i++) tick();
      cycle(0, 0, 0, 0, 0);
      idle(2);
      // Randomised traffic.
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(0, 2) == 0) f_lvl = ~f_lvl;
         cycle($urandom_range(0, 499) != 0, $urandom_range(0, 3) == 0, f_lvl,
               $urandom_range(0, 39) == 0, $urandom_range(0, 59) == 0);
      end
      idle(2);
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      #2;
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d responses pending, expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bird_motion.md
BIRD_MOTION -- requirements
Module: bird_motion

Interface
REQ-001 SHALL have parameter START_HEIGHT, default 9'd200, meaning the bird's hover/respawn height in pixels (larger values are lower on screen).
REQ-002 SHALL have parameter GROUND_HEIGHT, default 9'd440, meaning the largest legal height; reaching it kills the bird.
REQ-003 SHALL have parameter FLAP_VEL, default 6, meaning the magnitude of the upward velocity loaded on a flap.
REQ-004 SHALL have parameter MAX_FALL_VEL, default 8, meaning the downward velocity limit (gravity step fixed at 1 per frame).
REQ-005 SHALL have port clk, input, 1, meaning the system pixel clock.
REQ-006 SHALL have port rst_n, input, 1, meaning the synchronous active-low reset.
REQ-007 SHALL have port frame_tick, input, 1, meaning a one-clock pulse once per video frame.
REQ-008 SHALL have port flap_btn, input, 1, meaning the flap button level, already synchronised to clk.
REQ-009 SHALL have port game_start, input, 1, meaning a one-clock start/restart pulse.
REQ-010 SHALL have port collision, input, 1, meaning a level that is high while the bird overlaps a pipe.
REQ-011 SHALL have port bird_height, output, 9, meaning the bird's top-edge height, consumed by the bird renderer.
REQ-012 SHALL have port bird_valid, output, 1, meaning the bird is to be drawn.
REQ-013 SHALL have port bird_angle, output, 3, meaning the sprite tilt index, 0..4.
REQ-014 SHALL have port bird_dead, output, 1, meaning a level that is high while in DEAD.

Function
REQ-015 SHALL implement the states IDLE, FLY, DYING and DEAD; the state register, velocity register and all outputs SHALL be registered.
REQ-016 SHALL hold velocity as a signed 6-bit value (positive = downward); the height update SHALL be computed at 10 bits signed and then clamped.
REQ-017 SHALL set flap_pend on every clock where a 0->1 edge of flap_btn is detected; flap_pend SHALL be cleared on the frame_tick that consumes it, and an edge coinciding with that frame_tick SHALL be kept.
REQ-018 IDLE SHALL hold height at START_HEIGHT, velocity at 0 and angle at 1; game_start SHALL move the state to FLY, load velocity = -FLAP_VEL and clear flap_pend.
REQ-019 In FLY, each frame_tick SHALL do height <= clamp(height + vel); then vel <= -FLAP_VEL if flap_pend, else min(vel + 1, MAX_FALL_VEL).
REQ-020 On ceiling: if height + vel < 0, height SHALL be set to 0 and vel to 0 on that tick; the state SHALL stay FLY.
REQ-021 On ground: if height + vel >= GROUND_HEIGHT in FLY or DYING, height SHALL be set to GROUND_HEIGHT and the state SHALL move to DEAD on that tick.
REQ-022 collision sampled high in FLY SHALL move the state to DYING on the next clock; a simultaneous ground hit SHALL take priority and the state SHALL move to DEAD.
REQ-023 DYING SHALL apply gravity only on each frame_tick and ignore flaps; vel SHALL be forced to max(vel, 0) on entry.
REQ-024 DEAD SHALL freeze height and velocity with bird_dead = 1; game_start SHALL return the state to IDLE with height = START_HEIGHT and vel = 0.
REQ-025 game_start in FLY or DYING SHALL be ignored; frame_tick and game_start on the same clock in IDLE or DEAD SHALL apply the game_start transition only.
REQ-026 bird_angle SHALL be: vel < 0 -> 0; vel 0..1 -> 1; vel 2..3 -> 2; vel 4..5 -> 3; vel >= 6 -> 4; in DEAD, bird_angle SHALL be 4.
REQ-027 Outputs SHALL reflect the frame_tick update on the clock after the frame_tick (latency 1).
REQ-028 bird_valid SHALL go to 1 on the first frame_tick after reset and SHALL remain 1 until the next reset.

Reset
REQ-029 When rst_n is low at a clk edge, the block SHALL set state = IDLE, height = START_HEIGHT, vel = 0, flap_pend = 0, bird_valid = 0, bird_angle = 1 and bird_dead = 0.
REQ-030 Reset asserted in any state, including mid-flight, SHALL override every other input on that edge.

Verification
REQ-031 SHALL cover: reset, frame_tick, game_start, then 7 frame_ticks with no flap -> heights 194, 189, 185, 182, 180, 179, 179 and angles 0, 0, 0, 0, 0, 1, 1.
REQ-032 SHALL cover: in FLY at height 100 with vel = +5, a flap edge then frame_tick -> height 105, vel -6, bird_angle 0 one clock later.
REQ-033 SHALL cover: long free fall from START_HEIGHT -> vel saturates at 8 and never exceeds it; height clamps at 440; bird_dead = 1; height then stays frozen across further ticks.
REQ-034 SHALL cover: height 3 with vel = -6 on a frame_tick -> height 0 and vel 0, state remains FLY.
REQ-035 SHALL cover: collision pulse in FLY -> DYING; flaps ignored; fall to 440; DEAD; then game_start -> IDLE with height 200.
REQ-036 SHALL cover: rst_n low for one clock mid-FLY at height 300 -> next clock height 200, bird_valid 0, bird_dead 0, state IDLE.
